scan_signature_checker: RTL

SCAN_SIGNATURE_CHECKER -- requirements
Module: scan_signature_checker

---
 rtl/scan_signature_checker_if.sv | 25 ++
 rtl/scan_signature_checker.sv | 96 +++++++++
 2 files changed

// File: rtl/scan_signature_checker_if.sv
// Bus between a scan BIST controller and the signature checker: start/scan data in,
// status and signature out.
interface scan_signature_checker_if #(
   parameter int MISR_WIDTH = 16,
   parameter int NUM_CHAINS = 4
);
   logic                  bist_start;
   logic                  scan_valid;
   logic [NUM_CHAINS-1:0] scan_out;
   logic                  busy;
   logic                  bist_done;
   logic                  bist_pass;
   logic [MISR_WIDTH-1:0] signature;
   logic [15:0]           pattern_count;

   modport master (
      output bist_start, scan_valid, scan_out,
      input  busy, bist_done, bist_pass, signature, pattern_count
   );

   modport slave (
      input  bist_start, scan_valid, scan_out,
      output busy, bist_done, bist_pass, signature, pattern_count
   );
endinterface

// File: rtl/scan_signature_checker.sv
// MISR-based scan signature checker: compacts NUM_PATTERNS*CHAIN_LENGTH scan slices
// from SEED and compares the final signature against GOLDEN.
module scan_signature_checker #(
   parameter int                    MISR_WIDTH   = 16,
   parameter int                    NUM_CHAINS   = 4,
   parameter int                    CHAIN_LENGTH = 32,
   parameter int                    NUM_PATTERNS = 100,
   parameter logic [MISR_WIDTH-1:0] POLY         = 16'h8016,
   parameter logic [MISR_WIDTH-1:0] SEED         = 16'hFFFF,
   parameter logic [MISR_WIDTH-1:0] GOLDEN       = 16'h0000
) (
   input logic                    clock,
   input logic                    reset,
   scan_signature_checker_if.slave bus
);
   localparam int CW = (CHAIN_LENGTH > 1) ? $clog2(CHAIN_LENGTH) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, COLLECT, COMPARE, DONE} state_t;

   state_t                state, state_nx;
   logic [MISR_WIDTH-1:0] sig_q, sig_step;
   logic [CW-1:0]         shift_q;
   logic [15:0]           pcnt_q;
   logic                  pass_q;
   logic                  start_prev, start_armed;
   logic                  start_edge, pattern_last, run_last;

   // A start held high across reset must be seen low once before it can launch a run.
   assign start_edge   = bus.bist_start & ~start_prev & start_armed;
   assign pattern_last = (shift_q == CW'(CHAIN_LENGTH - 1));
   assign run_last     = bus.scan_valid & pattern_last & (pcnt_q == 16'(NUM_PATTERNS - 1));
   assign sig_step     = {sig_q[MISR_WIDTH-2:0], 1'b0}
                       ^ (sig_q[MISR_WIDTH-1] ? POLY : '0)
                       ^ MISR_WIDTH'(bus.scan_out);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start_edge) state_nx = LOAD;
         LOAD:    state_nx = COLLECT;
         COLLECT: if (run_last) state_nx = COMPARE;
         COMPARE: state_nx = DONE;
         DONE:    if (!bus.bist_start) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.busy      = (state == LOAD) || (state == COLLECT) || (state == COMPARE);
      bus.bist_done = (state == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sig_q       <= '0;
         shift_q     <= '0;
         pcnt_q      <= '0;
         pass_q      <= 1'b0;
         start_prev  <= 1'b0;
         start_armed <= 1'b0;
      end else begin
         start_prev <= bus.bist_start;
         if (!bus.bist_start) start_armed <= 1'b1;
         unique case (state)
            LOAD: begin
               sig_q   <= SEED;
               shift_q <= '0;
               pcnt_q  <= '0;
               pass_q  <= 1'b0;
            end
            COLLECT: begin
               if (bus.scan_valid) begin
                  sig_q <= sig_step;
                  if (pattern_last) begin
                     shift_q <= '0;
                     pcnt_q  <= pcnt_q + 16'd1;
                  end else begin
                     shift_q <= shift_q + CW'(1);
                  end
               end
            end
            COMPARE: pass_q <= (sig_q == GOLDEN);
            default: ;
         endcase
      end
   end

   assign bus.signature     = sig_q;
   assign bus.pattern_count = pcnt_q;
   assign bus.bist_pass     = pass_q;
endmodule
